// File: rtl/pc_msg_router_pkg.sv
// Shared definitions for the host message router: word tags, control opcodes,
// FSM state encoding and a constant log2 helper.
package pc_msg_router_pkg;

  localparam logic [1:0] TAG_PIXEL      = 2'b00;
  localparam logic [1:0] TAG_LAST_COEFF = 2'b01;
  localparam logic [1:0] TAG_COEFF      = 2'b10;
  localparam logic [1:0] TAG_CTRL       = 2'b11;

  localparam logic [5:0] OP_STATUS = 6'd0;
  localparam logic [5:0] OP_CLEAR  = 6'd1;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_BURST,
    ST_REPLY,
    ST_ERROR
  } state_t;

  // Ceiling log2; exact for the power-of-two burst lengths used here.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msg_fwd_reg.sv
// One-cycle forwarding register: latches the acked host word and raises the
// write strobe of whichever clock-crossing FIFO it was routed to.
module msg_fwd_reg
  import pc_msg_router_pkg::*;
#(
  parameter int XB_SIZE = 32
) (
  input  logic               bus_clk,
  input  logic               reset,
  input  logic               pix_sel,
  input  logic               dram_sel,
  input  logic [XB_SIZE-1:0] data_in,
  output logic               pix_wren,
  output logic               dram_wren,
  output logic [XB_SIZE-1:0] fwd_data
);

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      pix_wren  <= 1'b0;
      dram_wren <= 1'b0;
      fwd_data  <= '0;
    end else begin
      pix_wren  <= pix_sel;
      dram_wren <= dram_sel;
      if (pix_sel || dram_sel) fwd_data <= data_in;
    end
  end

endmodule

// File: rtl/pc_msg_router.sv
// Host message router: parses tagged words from the Xillybus FWFT FIFO, forwards
// pixels and coefficient bursts, answers status queries and flags protocol errors.
module pc_msg_router
  import pc_msg_router_pkg::*;
#(
  parameter int XB_SIZE     = 32,
  parameter int BURST_WORDS = 16,
  parameter int CNT_SIZE    = 16
) (
  input  logic               bus_clk,
  input  logic               reset,
  input  logic               pc_msg_empty,
  input  logic [XB_SIZE-1:0] pc_msg,
  output logic               pc_msg_ack,
  input  logic               pix_full,
  output logic               pix_wren,
  input  logic               dram_full,
  output logic               dram_wren,
  output logic [XB_SIZE-1:0] fwd_data,
  input  logic               fpga_msg_full,
  output logic               fpga_msg_valid,
  output logic [XB_SIZE-1:0] fpga_msg,
  output logic               coeff_done,
  output logic               error
);

  localparam int IDX_W = (log2(BURST_WORDS) > 0) ? int'(log2(BURST_WORDS)) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_WORDS - 1);

  state_t              state, state_nxt;
  logic [1:0]          tag;
  logic [5:0]          opcode;
  logic                pix_sel, dram_sel;
  logic [IDX_W-1:0]    burst_idx;
  logic                last_flag;
  logic [CNT_SIZE-1:0] n_burst, n_pixel;
  logic [31:0]         reply_word;

  assign tag        = pc_msg[1:0];
  assign opcode     = pc_msg[7:2];
  assign reply_word = {16'(n_burst), 8'(n_pixel), 4'b0000, coeff_done, error, 2'b11};

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) state <= ST_HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_msg_ack = 1'b0;
    pix_sel    = 1'b0;
    dram_sel   = 1'b0;
    case (state)
      ST_HDR: begin
        case (tag)
          TAG_PIXEL: begin
            pc_msg_ack = !pc_msg_empty && !pix_full;
            pix_sel    = pc_msg_ack;
          end
          TAG_COEFF, TAG_LAST_COEFF: begin
            pc_msg_ack = !pc_msg_empty && !dram_full;
            dram_sel   = pc_msg_ack;
            if (pc_msg_ack) state_nxt = ST_BURST;
          end
          default: begin
            pc_msg_ack = !pc_msg_empty && !fpga_msg_full;
            if (pc_msg_ack) begin
              if (opcode == OP_STATUS)     state_nxt = ST_REPLY;
              else if (opcode != OP_CLEAR) state_nxt = ST_ERROR;
            end
          end
        endcase
      end
      ST_BURST: begin
        pc_msg_ack = !pc_msg_empty && !dram_full;
        dram_sel   = pc_msg_ack;
        if (pc_msg_ack && burst_idx == LAST_IDX) state_nxt = ST_HDR;
      end
      ST_REPLY: begin
        if (!fpga_msg_full) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_ERROR;
    endcase
  end

  // burst_idx is exactly log2(BURST_WORDS) wide, so the increment past the
  // last word wraps it back to 0 without an explicit clear.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      burst_idx      <= '0;
      last_flag      <= 1'b0;
      n_burst        <= '0;
      n_pixel        <= '0;
      coeff_done     <= 1'b0;
      error          <= 1'b0;
      fpga_msg_valid <= 1'b0;
      fpga_msg       <= '0;
    end else begin
      fpga_msg_valid <= 1'b0;
      case (state)
        ST_HDR: begin
          if (pc_msg_ack) begin
            case (tag)
              TAG_PIXEL: n_pixel <= n_pixel + 1'b1;
              TAG_COEFF, TAG_LAST_COEFF: begin
                burst_idx <= IDX_W'(1);
                last_flag <= (tag == TAG_LAST_COEFF);
              end
              default: begin
                if (opcode == OP_CLEAR) begin
                  n_burst    <= '0;
                  n_pixel    <= '0;
                  coeff_done <= 1'b0;
                end else if (opcode != OP_STATUS) begin
                  error <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_BURST: begin
          if (pc_msg_ack) begin
            burst_idx <= burst_idx + 1'b1;
            if (burst_idx == LAST_IDX) begin
              n_burst <= n_burst + 1'b1;
              if (last_flag) coeff_done <= 1'b1;
            end
          end
        end
        ST_REPLY: begin
          if (!fpga_msg_full) begin
            fpga_msg_valid <= 1'b1;
            fpga_msg       <= XB_SIZE'(reply_word);
          end
        end
        default: ;
      endcase
    end
  end

  msg_fwd_reg #(.XB_SIZE(XB_SIZE)) u_fwd (
    .bus_clk   (bus_clk),
    .reset     (reset),
    .pix_sel   (pix_sel),
    .dram_sel  (dram_sel),
    .data_in   (pc_msg),
    .pix_wren  (pix_wren),
    .dram_wren (dram_wren),
    .fwd_data  (fwd_data)
  );

endmodule

// File: tb/tb_pc_msg_router.sv
// Scoreboard bench for pc_msg_router: a host FIFO model feeds words, expected
// FIFO writes and status replies are queued and checked as the DUT emits them.
module tb_pc_msg_router;

  logic        bus_clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_msg_empty;
  logic [31:0] pc_msg;
  logic        pc_msg_ack;
  logic        pix_full = 1'b0;
  logic        pix_wren;
  logic        dram_full = 1'b0;
  logic        dram_wren;
  logic [31:0] fwd_data;
  logic        fpga_msg_full = 1'b0;
  logic        fpga_msg_valid;
  logic [31:0] fpga_msg;
  logic        coeff_done;
  logic        error;

  pc_msg_router #(.XB_SIZE(32), .BURST_WORDS(16), .CNT_SIZE(16)) dut (
    .bus_clk        (bus_clk),
    .reset          (reset),
    .pc_msg_empty   (pc_msg_empty),
    .pc_msg         (pc_msg),
    .pc_msg_ack     (pc_msg_ack),
    .pix_full       (pix_full),
    .pix_wren       (pix_wren),
    .dram_full      (dram_full),
    .dram_wren      (dram_wren),
    .fwd_data       (fwd_data),
    .fpga_msg_full  (fpga_msg_full),
    .fpga_msg_valid (fpga_msg_valid),
    .fpga_msg       (fpga_msg),
    .coeff_done     (coeff_done),
    .error          (error)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    bit          dram;
    logic [31:0] data;
  } fwd_t;

  fwd_t        exp_q[$];
  logic [31:0] rep_q[$];
  int          ack_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_count = 0;
  int          cyc = 0;
  bit          ack_s = 1'b0;

  // Host FWFT FIFO model
  logic [31:0] hmem[0:255];
  int unsigned hw = 0;
  int unsigned hr = 0;
  assign pc_msg       = hmem[hr[7:0]];
  assign pc_msg_empty = (hw == hr);

  always @(negedge bus_clk) ack_s = pc_msg_ack;

  always @(posedge bus_clk) begin
    cyc = cyc + 1;
    if (ack_s && !reset) begin
      hr <= hr + 1;
      ack_count = ack_count + 1;
      ack_cyc.push_back(cyc);
    end
  end

  // Output monitor: every FIFO write and reply must match the head of its queue
  always @(negedge bus_clk) begin
    fwd_t e;
    logic [31:0] r;
    if (pix_wren || dram_wren) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fwd_unexpected: pix_wren=%0b dram_wren=%0b data=%h, required no write",
                 pix_wren, dram_wren, fwd_data);
      end else begin
        e = exp_q.pop_front();
        if ({pix_wren, dram_wren} !== {~e.dram, e.dram} || fwd_data !== e.data) begin
          n_fail++;
          $display("FAIL fwd_write: pix=%0b dram=%0b data=%h, required pix=%0b dram=%0b data=%h",
                   pix_wren, dram_wren, fwd_data, ~e.dram, e.dram, e.data);
        end
      end
    end
    if (fpga_msg_valid) begin
      n_checks++;
      if (rep_q.size() == 0) begin
        n_fail++;
        $display("FAIL reply_unexpected: fpga_msg=%h, required no reply", fpga_msg);
      end else begin
        r = rep_q.pop_front();
        if (fpga_msg !== r) begin
          n_fail++;
          $display("FAIL reply: fpga_msg=%h, required %h", fpga_msg, r);
        end
      end
    end
  end

  task automatic push_host(input logic [31:0] w);
    hmem[hw[7:0]] = w;
    hw = hw + 1;
  endtask

  task automatic exp_fwd(input bit dram, input logic [31:0] w);
    fwd_t e;
    e.dram = dram;
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (hw == hr && exp_q.size() == 0 && rep_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge bus_clk); #1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: host left=%0d fwd left=%0d reply left=%0d, required 0/0/0",
               name, hw - hr, exp_q.size(), rep_q.size());
    end
    repeat (2) @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input string name);
    for (int i = 0; i < 50; i++) begin
      if (ack_count >= target) break;
      @(posedge bus_clk); #1;
    end
    n_checks++;
    if (ack_count < target) begin
      n_fail++;
      $display("FAIL %s_ack_timeout: acks=%0d, required %0d", name, ack_count, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge bus_clk);
    #1;
    n_checks++;
    if ({pc_msg_ack, pix_wren, dram_wren, fpga_msg_valid, coeff_done, error} !== 6'b0 ||
        fwd_data !== 32'h0 || fpga_msg !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b pix=%b dram=%b valid=%b done=%b err=%b fwd=%h msg=%h, required all 0",
               pc_msg_ack, pix_wren, dram_wren, fpga_msg_valid, coeff_done, error, fwd_data, fpga_msg);
    end
    reset = 1'b0;
  endtask

  task automatic test_pixel();
    int base;
    base = ack_count;
    push_host(32'h0000_0100); exp_fwd(1'b0, 32'h0000_0100);
    push_host(32'h0000_0200); exp_fwd(1'b0, 32'h0000_0200);
    wait_acks(base + 1, "pixel");
    n_checks++;
    if (pix_wren !== 1'b1 || dram_wren !== 1'b0 || fwd_data !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL pixel_latency1: pix=%b dram=%b fwd=%h, required 1 0 00000100", pix_wren, dram_wren, fwd_data);
    end
    @(posedge bus_clk); #1;
    n_checks++;
    if (pix_wren !== 1'b1 || fwd_data !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL pixel_latency2: pix=%b fwd=%h, required 1 00000200", pix_wren, fwd_data);
    end
    @(posedge bus_clk); #1;
    n_checks++;
    if (pix_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL pixel_wren_end: pix=%b, required 0", pix_wren);
    end
    wait_drain("pixel");
  endtask

  task automatic test_burst();
    int base;
    logic [31:0] w;
    base = ack_count;
    push_host(32'h0000_000E); exp_fwd(1'b1, 32'h0000_000E);
    for (int i = 1; i < 16; i++) begin
      w = 32'h1000_0000 | (i << 4) | (i % 4);
      push_host(w); exp_fwd(1'b1, w);
    end
    push_host(32'h0000_0000); exp_fwd(1'b0, 32'h0000_0000);
    wait_drain("burst");
    n_checks++;
    if (ack_count - base != 17) begin
      n_fail++;
      $display("FAIL burst_acks: acks=%0d, required 17", ack_count - base);
    end
  endtask

  task automatic test_last_burst_stall();
    int base, idx0, idle;
    logic [31:0] w;
    n_checks++;
    if (coeff_done !== 1'b0) begin
      n_fail++;
      $display("FAIL coeff_done_before: coeff_done=%b, required 0", coeff_done);
    end
    base = ack_count;
    idx0 = ack_cyc.size();
    push_host(32'h0000_000D); exp_fwd(1'b1, 32'h0000_000D);
    for (int i = 1; i < 16; i++) begin
      w = 32'h2000_0000 | (i << 4);
      push_host(w); exp_fwd(1'b1, w);
    end
    wait_acks(base + 7, "stall");
    dram_full = 1'b1;
    repeat (5) @(posedge bus_clk);
    #1;
    dram_full = 1'b0;
    wait_drain("stall");
    idle = 0;
    for (int i = idx0 + 1; i < idx0 + 16 && i < ack_cyc.size(); i++)
      idle += ack_cyc[i] - ack_cyc[i-1] - 1;
    n_checks++;
    if (ack_count - base != 16 || idle != 5) begin
      n_fail++;
      $display("FAIL stall_gap: acks=%0d idle=%0d, required 16 acks 5 idle", ack_count - base, idle);
    end
    n_checks++;
    if (coeff_done !== 1'b1) begin
      n_fail++;
      $display("FAIL coeff_done_after: coeff_done=%b, required 1", coeff_done);
    end
  endtask

  task automatic test_status_full();
    int base;
    fpga_msg_full = 1'b1;
    base = ack_count;
    push_host(32'h0000_0003);
    repeat (3) @(posedge bus_clk);
    #1;
    n_checks++;
    if (ack_count != base) begin
      n_fail++;
      $display("FAIL status_held: acks=%0d, required %0d", ack_count, base);
    end
    // 2 bursts, 3 pixels, coeff_done=1, error=0
    rep_q.push_back(32'h0002_030B);
    fpga_msg_full = 1'b0;
    wait_drain("status");
  endtask

  task automatic test_clear();
    push_host(32'h0000_0007);
    push_host(32'h0000_0003);
    rep_q.push_back(32'h0000_0003);
    wait_drain("clear");
    n_checks++;
    if (coeff_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_coeff_done: coeff_done=%b, required 0", coeff_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    push_host(32'h0000_0300); exp_fwd(1'b0, 32'h0000_0300);
    push_host(32'h0000_0400); exp_fwd(1'b0, 32'h0000_0400);
    push_host(32'h0000_00A2); exp_fwd(1'b1, 32'h0000_00A2);
    for (int i = 1; i < 16; i++) begin
      w = 32'h3000_0000 | (i << 8) | 32'h3;
      push_host(w); exp_fwd(1'b1, w);
    end
    push_host(32'h0000_0500); exp_fwd(1'b0, 32'h0000_0500);
    push_host(32'h0000_0003);
    rep_q.push_back(32'h0001_0303);
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_burst();
    push_host(32'h0000_000A); exp_fwd(1'b1, 32'h0000_000A);
    for (int i = 1; i < 5; i++) begin
      push_host(32'h4000_0000 | (i << 4)); exp_fwd(1'b1, 32'h4000_0000 | (i << 4));
    end
    wait_drain("midburst_pre");
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (fwd_data !== 32'h0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_reset: fwd=%h err=%b, required 0 0", fwd_data, error);
    end
    @(posedge bus_clk); #1;
    reset = 1'b0;
    push_host(32'h0000_0600); exp_fwd(1'b0, 32'h0000_0600);
    push_host(32'h0000_0003);
    rep_q.push_back(32'h0000_0103);
    wait_drain("midburst_post");
  endtask

  task automatic test_error();
    int base;
    base = ack_count;
    push_host(32'h0000_0017);
    push_host(32'h0000_0100);
    wait_acks(base + 1, "error");
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL error_set: error=%b, required 1", error);
    end
    repeat (10) @(posedge bus_clk);
    #1;
    n_checks++;
    if (ack_count != base + 1 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL error_absorb: acks=%0d error=%b, required %0d 1", ack_count - base, error, 1);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_async_clear: error=%b, required 0", error);
    end
    @(posedge bus_clk); #1;
    exp_fwd(1'b0, 32'h0000_0100);
    reset = 1'b0;
    wait_drain("error_recover");
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_after_recover: error=%b, required 0", error);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pixel();
    test_burst();
    test_last_burst_stall();
    test_status_full();
    test_clear();
    test_back_to_back();
    test_reset_mid_burst();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_msg_router.md
Name: pc_msg_router

Overview:
- bus_clk-domain front end between the Xillybus host FIFO (first-word-fall-through) and the two clock-crossing FIFOs, pixel and DRAM.
- Parses host words by a 2-bit tag, forwards single pixel words and fixed-length coefficient bursts to the correct FIFO with flow control, and services control opcodes with a status reply on the FPGA→host stream.
- Raises a sticky error on protocol violations.

Parameters:
- XB_SIZE, 32, host word width; must be ≥32.
- BURST_WORDS, 16, words per coefficient burst, equal to 2*APP_DATA_WIDTH/XB_SIZE; must be a power of 2.
- CNT_SIZE, 16, width of the burst and pixel counters.

Ports:
- bus_clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- pc_msg_empty  in  1  host FIFO empty.
- pc_msg  in  XB_SIZE  host FIFO head word.
- pc_msg_ack  out  1  pops the host FIFO.
- pix_full  in  1  pixel FIFO almost_full.
- pix_wren  out  1  pixel FIFO write.
- dram_full  in  1  DRAM FIFO almost_full.
- dram_wren  out  1  DRAM FIFO write.
- fwd_data  out  XB_SIZE  data for either FIFO.
- fpga_msg_full  in  1  host-bound FIFO full.
- fpga_msg_valid  out  1  host-bound write.
- fpga_msg  out  XB_SIZE  status reply.
- coeff_done  out  1  a tag-01 burst has completed.
- error  out  1  sticky protocol error.

Behaviour:
- Tag = pc_msg[1:0], examined only on the header word in HDR.
  - 00: pixel word, 1 word.
  - 10: coefficient burst of BURST_WORDS words, header included.
  - 01: last coefficient burst, same length as 10.
  - 11: control; opcode = pc_msg[7:2].
- States: HDR, BURST, REPLY, ERROR. Reset → HDR.
- pc_msg_ack is combinational.
  - HDR: ack = !pc_msg_empty && route ok, where route ok is !pix_full for tag 00, !dram_full for tag 10/01, and !fpga_msg_full for tag 11.
  - BURST: ack = !pc_msg_empty && !dram_full.
  - REPLY and ERROR: ack = 0.
- Forwarding latency is 1 cycle. On an acked word the block registers fwd_data <= pc_msg and raises pix_wren or dram_wren in the next cycle only. The almost_full inputs absorb this one in-flight word.
- Burst counter burst_idx, log2(BURST_WORDS) bits:
  - Acked tag 10/01 header: burst_idx <= 1; go to BURST; set last_flag = (tag==01).
  - In BURST, every acked word increments burst_idx. Word tags are not inspected in BURST.
  - When the acked word has burst_idx==BURST_WORDS-1: counter wraps to 0; return to HDR; n_burst++; if last_flag then coeff_done <= 1.
- Tag 00 acked: n_pixel++.
- Control opcodes:
  - 0 = status query: go to REPLY.
  - 1 = clear: n_burst, n_pixel and coeff_done <= 0; stay in HDR; no reply.
  - Any other opcode: state <= ERROR, error <= 1.
- REPLY:
  - If !fpga_msg_full: fpga_msg_valid <= 1 for one cycle; fpga_msg <= {n_burst[15:0], n_pixel[7:0], 4'b0, coeff_done, error, 2'b11}, upper bits above 32 zero; return to HDR.
  - Otherwise hold REPLY with no ack.
- Counters wrap modulo 2^CNT_SIZE.
- ERROR is absorbing until reset; all wren/valid outputs are 0 in it.
- A full input rising mid-burst stalls ack only; burst position is preserved.
- Reset values:
  - All wren/valid = 0, fwd_data = 0, fpga_msg = 0.
  - coeff_done = 0, error = 0, counters = 0, burst_idx = 0.
- Reset asserted mid-burst aborts the burst. The next word after reset is parsed as a header.

Decomposition:
- Shared package holds:
  - tag constants: TAG_PIXEL=2'b00, TAG_LAST_COEFF=2'b01, TAG_COEFF=2'b10, TAG_CTRL=2'b11;
  - opcodes OP_STATUS=0, OP_CLEAR=1;
  - state encodings;
  - the log2 function.
- One natural sub-module, msg_fwd_reg: the 1-cycle output register with its wren select.

Test Plan:
- Reset, then pixel words 0x00000100, 0x00000200 with FIFO non-empty → pix_wren for 2 cycles, each 1 cycle after its ack; fwd_data matches; dram_wren stays 0.
- Header 0x0000000E (tag 10) + 15 words → 16 dram_wren; state back to HDR; n_burst=1; a following 0x00000000 goes to the pixel FIFO.
- Tag-01 burst with dram_full asserted on word 7 for 5 cycles → ack gaps exactly 5 cycles; still 16 writes total; coeff_done=1 after the 16th.
- Status query 0x00000003 with fpga_msg_full=1 for 3 cycles → no acks meanwhile; then 1-cycle fpga_msg_valid with fpga_msg[3:0]=4'b1011 when coeff_done=1 and error=0.
- Clear 0x00000007 after 2 bursts → n_burst=0 and coeff_done=0; a subsequent status reply reads 0x0000_00_0_3.
- Opcode 5 (0x00000017) → error=1 next cycle; further words never acked; async reset clears error and returns to HDR.
